rxll_fifo: RTL
==============

RXLL_FIFO -- requirements
Module: rxll_fifo

Interface
REQ-001 SHALL have parameter C_DEPTH, 512, storage depth in 36-bit words (power of two).
REQ-002 SHALL have parameter C_ALMOST_FULL_THRESH, 256, wr_count level at or above which wr_almost_full asserts.
REQ-003 SHALL have parameter C_ALMOST_EMPTY_THRESH, 16, rd_count level at or below which rd_almost_empty asserts.
REQ-004 clk  input  1  single clock; one clock, reset is synchronous and active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wr_di  input  36  [31:0] data, [32] sof, [33] reserved, [34] eof, [35] frame error (valid with eof).
REQ-007 wr_en  input  1  write strobe from link layer.
REQ-008 wr_full  output  1  no free word.
REQ-009 wr_almost_full  output  1  wr_count >= C_ALMOST_FULL_THRESH.
REQ-010 wr_count  output  10  occupancy including uncommitted words.
REQ-011 rd_do  output  36  oldest committed word, first-word-fall-through.
REQ-012 rd_en  input  1  pop strobe.
REQ-013 rd_empty  output  1  no committed word available.
REQ-014 rd_almost_empty  output  1  rd_count <= C_ALMOST_EMPTY_THRESH.
REQ-015 rd_count  output  10  committed words not yet read.
REQ-016 rd_eof_rdy  output  1  at least one complete frame held.
REQ-017 frame_drop  output  1  one-cycle pulse when a frame is discarded.
REQ-018 overflow  output  1  one-cycle pulse when a write hits a full FIFO.

Function
REQ-019 SHALL keep three pointers of log2(C_DEPTH)+1 bits: wr_ptr (speculative), cm_ptr (committed), rd_ptr.
REQ-020 SHALL run write FSM states WAIT_SOF, IN_FRAME, DISCARD.
REQ-021 WAIT_SOF: wr_en with sof=0 SHALL be ignored; sof=1 stores word, goes IN_FRAME (eof=1 in same word commits and stays WAIT_SOF).
REQ-022 IN_FRAME: accepted word with eof=1,err=0 SHALL set cm_ptr to wr_ptr+1 (word included) and go WAIT_SOF.
REQ-023 IN_FRAME: accepted word with eof=1,err=1 SHALL set wr_ptr to cm_ptr, pulse frame_drop, go WAIT_SOF.
REQ-024 IN_FRAME: sof=1 SHALL roll wr_ptr back to cm_ptr, pulse frame_drop, and store the new word as start of a new frame.
REQ-025 IN_FRAME: wr_en while wr_full SHALL pulse overflow, roll wr_ptr back to cm_ptr, go DISCARD.
REQ-026 DISCARD: words SHALL be dropped; eof=1 pulses frame_drop, goes WAIT_SOF; sof=1 starts new frame as REQ-021.
REQ-027 wr_full SHALL equal (wr_ptr - rd_ptr) == C_DEPTH; wr_count SHALL equal wr_ptr - rd_ptr.
REQ-028 rd_empty SHALL equal rd_ptr == cm_ptr; rd_count SHALL equal cm_ptr - rd_ptr; uncommitted words never visible on read side.
REQ-029 Committed word SHALL appear on rd_do with rd_empty=0 on the cycle after the commit edge.
REQ-030 rd_en with rd_empty=0 SHALL advance rd_ptr; next word on rd_do following cycle; rd_en while empty ignored, no state change.
REQ-031 SHALL hold frame counter: +1 on commit, -1 on pop of eof word, unchanged if both same cycle; rd_eof_rdy = counter != 0.
REQ-032 Pointer arithmetic SHALL wrap modulo 2*C_DEPTH; full/empty correct across wrap.
REQ-033 Simultaneous write and read SHALL both take effect; a read freeing space makes the same-cycle write still see wr_full from the prior state.

Reset
REQ-034 rst SHALL zero all pointers and frame counter, set FSM WAIT_SOF, discard partial and committed data.
REQ-035 After reset: rd_empty=1, rd_almost_empty=1, wr_full=0, wr_almost_full=0, wr_count=0, rd_count=0, rd_eof_rdy=0, frame_drop=0, overflow=0, rd_do=36'h0.
REQ-036 rst asserted mid-frame SHALL take priority over any same-cycle wr_en/rd_en.

Verification
REQ-037 Write 4-word good frame (sof on word0, eof on word3, err=0) -> rd_empty falls cycle after word3, rd_count=4, rd_eof_rdy=1; 4 pops return data in order, rd_eof_rdy=0 after eof pop.
REQ-038 Write 3-word frame ending eof=1,err=1 -> frame_drop one pulse, wr_count returns 0, rd_empty stays 1.
REQ-039 Write 600-word frame into empty 512 FIFO -> overflow pulse at word 513, frame_drop at eof, wr_count=0, no data readable.
REQ-040 Good frame A committed, frame B with sof mid-B -> frame_drop once, A readable intact, restarted B commits correctly.
REQ-041 Continuous 1000 two-word frames with concurrent reads -> correct data order across pointer wrap, never full/empty glitch, rd_eof_rdy tracks counter.
REQ-042 Assert rst mid-frame with committed data present -> next cycle all outputs at REQ-035 values.

Source files
------------

// File: rtl/rxll_fifo.sv
// Frame-aware link-layer receive FIFO: words become readable only once their frame commits on a clean eof.
// Bad, overflowed or restarted frames are rolled back to the last commit point; read side is first-word-fall-through.
module rxll_fifo #(
  parameter int C_DEPTH               = 512,
  parameter int C_ALMOST_FULL_THRESH  = 256,
  parameter int C_ALMOST_EMPTY_THRESH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] wr_di,
  input  logic        wr_en,
  output logic        wr_full,
  output logic        wr_almost_full,
  output logic [9:0]  wr_count,
  output logic [35:0] rd_do,
  input  logic        rd_en,
  output logic        rd_empty,
  output logic        rd_almost_empty,
  output logic [9:0]  rd_count,
  output logic        rd_eof_rdy,
  output logic        frame_drop,
  output logic        overflow
);

  localparam int AW = $clog2(C_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] L_DEPTH = PW'(C_DEPTH);
  localparam logic [PW-1:0] L_AFULL = PW'(C_ALMOST_FULL_THRESH);
  localparam logic [PW-1:0] L_AEMPTY = PW'(C_ALMOST_EMPTY_THRESH);

  typedef enum logic [1:0] {S_WAIT_SOF, S_IN_FRAME, S_DISCARD} state_t;

  state_t        r_state;
  logic [PW-1:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, r_frames;
  logic          r_frame_drop, r_overflow;
  logic [35:0]   r_mem [C_DEPTH];

  logic          w_sof, w_eof, w_err;
  logic          w_accept, w_no_room, w_mem_we, w_commit;
  logic          w_empty, w_pop, w_pop_eof;
  logic [PW-1:0] w_base, w_wr_used, w_rd_used;
  logic [35:0]   w_head;

  assign w_sof = wr_di[32];
  assign w_eof = wr_di[34];
  assign w_err = wr_di[35];

  // A sof word always lands at the commit point, discarding any partial frame in front of it.
  assign w_accept  = wr_en && ((r_state == S_IN_FRAME) || w_sof);
  assign w_base    = w_sof ? r_cm_ptr : r_wr_ptr;
  assign w_no_room = (w_base - r_rd_ptr) == L_DEPTH;
  assign w_mem_we  = w_accept && !w_no_room && !rst;
  assign w_commit  = w_mem_we && w_eof && !w_err;

  assign w_empty   = r_rd_ptr == r_cm_ptr;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop     = rd_en && !w_empty;
  assign w_pop_eof = w_pop && w_head[34];

  assign w_wr_used = r_wr_ptr - r_rd_ptr;
  assign w_rd_used = r_cm_ptr - r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_base[AW-1:0]] <= wr_di;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_WAIT_SOF;
      r_wr_ptr     <= '0;
      r_cm_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_frames     <= '0;
      r_frame_drop <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_drop <= 1'b0;
      r_overflow   <= 1'b0;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_commit && !w_pop_eof)      r_frames <= r_frames + 1'b1;
      else if (!w_commit && w_pop_eof) r_frames <= r_frames - 1'b1;

      if (w_accept) begin
        if ((r_state == S_IN_FRAME) && w_sof) r_frame_drop <= 1'b1;
        if (w_no_room) begin
          r_overflow <= 1'b1;
          r_wr_ptr   <= r_cm_ptr;
          // An overflowing word that also closes the frame ends the discard right here.
          if (w_eof) begin
            r_frame_drop <= 1'b1;
            r_state      <= S_WAIT_SOF;
          end else begin
            r_state      <= S_DISCARD;
          end
        end else if (w_eof) begin
          r_state <= S_WAIT_SOF;
          if (w_err) begin
            r_wr_ptr     <= r_cm_ptr;
            r_frame_drop <= 1'b1;
          end else begin
            r_wr_ptr <= w_base + 1'b1;
            r_cm_ptr <= w_base + 1'b1;
          end
        end else begin
          r_wr_ptr <= w_base + 1'b1;
          r_state  <= S_IN_FRAME;
        end
      end else if (wr_en && (r_state == S_DISCARD) && w_eof) begin
        r_frame_drop <= 1'b1;
        r_state      <= S_WAIT_SOF;
      end
    end
  end

  assign wr_full         = w_wr_used == L_DEPTH;
  assign wr_almost_full  = w_wr_used >= L_AFULL;
  assign wr_count        = 10'(w_wr_used);
  assign rd_empty        = w_empty;
  assign rd_almost_empty = w_rd_used <= L_AEMPTY;
  assign rd_count        = 10'(w_rd_used);
  assign rd_do           = w_empty ? 36'h0 : w_head;
  assign rd_eof_rdy      = r_frames != '0;
  assign frame_drop      = r_frame_drop;
  assign overflow        = r_overflow;

endmodule
